// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the debug-unit transmitter.
//   NBITS_DEF : default data bits per frame
//   SB_TICK   : oversampling ticks per bit (fixed at 16)
//   MID_TICK  : tick index that marks the middle of the start bit
//   LAST_TICK : tick index that marks the middle of data/parity/stop bits
//   uart_state_e : frame state encodings
package uart_pkg;

  localparam int         NBITS_DEF = 8;
  localparam int         SB_TICK   = 16;
  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus bundle.
//   i_baud_rate  : 16x oversampling tick (one clk wide)
//   i_rx         : asynchronous serial line, idle high
//   o_data       : last received byte
//   o_rx_done    : one-cycle frame-complete strobe
//   o_frame_err  : stop bit sampled low
//   o_parity_err : parity mismatch (0 unless UART_RX_PARITY_EN)
// slave  : the receiver
// master : whoever drives the line and consumes the bytes
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) ();

  logic             i_baud_rate;
  logic             i_rx;
  logic [NBITS-1:0] o_data;
  logic             o_rx_done;
  logic             o_frame_err;
  logic             o_parity_err;

  modport slave (
    input  i_baud_rate, i_rx,
    output o_data, o_rx_done, o_frame_err, o_parity_err
  );

  modport master (
    output i_baud_rate, i_rx,
    input  o_data, o_rx_done, o_frame_err, o_parity_err
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, loads RST_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver using a shared 16x oversampling tick.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   bus (slave)  : i_baud_rate, i_rx in; o_data, o_rx_done, o_frame_err,
//                  o_parity_err out
// Build option: define UART_RX_PARITY_EN to receive an even parity bit
// between the last data bit and the stop bit.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (no tick needed to leave)
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling NBITS data bits LSB first at mid bit
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit at mid bit, publishing the byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int             BW       = $clog2(NBITS);
  localparam logic [BW-1:0]  LAST_BIT = BW'(NBITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.i_rx),
    .q_o (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [3:0]       tick_q,  tick_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] data_q,  data_d;
  logic             done_q,  done_d;
  logic             ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q,   par_d;
  logic             perr_q,  perr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (bus.i_baud_rate) begin
          if (tick_q == MID_TICK) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (bus.i_baud_rate) begin
          if (tick_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[NBITS-1:1]};
            tick_d  = '0;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.i_baud_rate) begin
          if (tick_q == LAST_TICK) begin
            par_d   = rx_s;
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`endif

      STOP: begin
        if (bus.i_baud_rate) begin
          if (tick_q == LAST_TICK) begin
            data_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`endif
            // Leaving at mid stop bit gives half a bit of margin to catch
            // a back-to-back start edge.
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_rx_done   = done_q;
  assign bus.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = perr_q;
`else
  assign bus.o_parity_err = 1'b0;
`endif

endmodule
